// File: rtl/sram_1rw1r_arbiter_pkg.sv
// sram_arb_pkg: shared widths, requester ids and the port-0 request bundle for the SRAM arbiter
package sram_arb_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int BE_W = DATA_W / 8;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
  typedef struct packed {
    logic we;
    logic [BE_W-1:0] be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port0_req_t;
endpackage

// File: rtl/sram_1rw1r_arbiter_if.sv
// sram_1rw1r_arbiter_if: requester A/B (rw), requester C (read) and 1RW+1R macro pins
// slave modport is the arbiter's view, master the view of the surrounding interconnect and macro
interface sram_1rw1r_arbiter_if;
  import sram_arb_pkg::*;
  logic a_req_i, a_we_i, a_gnt_o, a_rvalid_o;
  logic [BE_W-1:0] a_be_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_wdata_i, a_rdata_o;
  logic b_req_i, b_we_i, b_gnt_o, b_rvalid_o;
  logic [BE_W-1:0] b_be_i;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_wdata_i, b_rdata_o;
  logic c_req_i, c_gnt_o, c_rvalid_o;
  logic [ADDR_W-1:0] c_addr_i;
  logic [DATA_W-1:0] c_rdata_o;
  logic csb0_o, web0_o, csb1_o;
  logic [BE_W-1:0] wmask0_o;
  logic [ADDR_W-1:0] addr0_o, addr1_o;
  logic [DATA_W-1:0] din0_o, dout0_i, dout1_i;
  modport slave (
    input a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
    input b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
    input c_req_i, c_addr_i, dout0_i, dout1_i,
    output a_gnt_o, a_rvalid_o, a_rdata_o, b_gnt_o, b_rvalid_o, b_rdata_o,
    output c_gnt_o, c_rvalid_o, c_rdata_o,
    output csb0_o, web0_o, wmask0_o, addr0_o, din0_o, csb1_o, addr1_o
  );
  modport master (
    output a_req_i, a_we_i, a_be_i, a_addr_i, a_wdata_i,
    output b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
    output c_req_i, c_addr_i, dout0_i, dout1_i,
    input a_gnt_o, a_rvalid_o, a_rdata_o, b_gnt_o, b_rvalid_o, b_rdata_o,
    input c_gnt_o, c_rvalid_o, c_rdata_o,
    input csb0_o, web0_o, wmask0_o, addr0_o, din0_o, csb1_o, addr1_o
  );
endinterface

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: 2-way round-robin arbiter; req[0]=A, req[1]=B, one-hot gnt, gnt_id of the winner
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output req_id_e gnt_id
);
  req_id_e ptr, ptr_d;
  always_ff @(posedge clk_i) ptr <= rst_i ? REQ_A : ptr_d;
  // the pointer only moves on contention, so a lone requester never steals the next turn
  always_comb begin
    gnt = &req ? (ptr == REQ_A ? 2'b01 : 2'b10) : req;
    gnt_id = gnt[1] ? REQ_B : REQ_A;
    ptr_d = &req ? (ptr == REQ_A ? REQ_B : REQ_A) : ptr;
  end
endmodule

// File: rtl/sram_1rw1r_arbiter.sv
// sram_1rw1r_arbiter: shares a 1RW+1R SRAM macro between A/B (port 0, round-robin) and C (port 1)
// clk_i/rst_i: clock and synchronous active-high reset; bus: requester handshakes and macro pins
module sram_1rw1r_arbiter
  import sram_arb_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  sram_1rw1r_arbiter_if.slave bus
);
  logic [1:0] req, gnt;
  req_id_e gnt_id, s1_id;
  port0_req_t a_op, b_op, p0;
  logic p0_fire, p0_wr, collide, c_fire, rd0;
  logic s1_vld0, s1_we, s1_vld1;
  logic a_rv, b_rv, c_rv;
  logic [DATA_W-1:0] a_rd, b_rd, c_rd;
  assign req = {bus.b_req_i, bus.a_req_i} & {2{~rst_i}};
  sram_rr_arb2 u_arb (.clk_i, .rst_i, .req, .gnt, .gnt_id);
  // a C read of the word being written this cycle is held off one cycle so it sees the new data
  always_comb begin
    a_op = '{we: bus.a_we_i, be: bus.a_be_i, addr: bus.a_addr_i, wdata: bus.a_wdata_i};
    b_op = '{we: bus.b_we_i, be: bus.b_be_i, addr: bus.b_addr_i, wdata: bus.b_wdata_i};
    p0 = gnt_id == REQ_B ? b_op : a_op;
    p0_fire = |gnt;
    p0_wr = p0_fire & p0.we;
    collide = p0_wr & (p0.addr == bus.c_addr_i);
    c_fire = bus.c_req_i & ~rst_i & ~collide;
    rd0 = s1_vld0 & ~s1_we;
  end
  assign bus.a_gnt_o = gnt[0];
  assign bus.b_gnt_o = gnt[1];
  assign bus.c_gnt_o = c_fire;
  assign bus.csb0_o = ~p0_fire;
  assign bus.web0_o = ~p0_wr;
  assign bus.wmask0_o = p0_wr ? p0.be : '0;
  assign bus.addr0_o = p0_fire ? p0.addr : '0;
  assign bus.din0_o = p0_fire ? p0.wdata : '0;
  assign bus.csb1_o = ~c_fire;
  assign bus.addr1_o = c_fire ? bus.c_addr_i : '0;
  assign bus.a_rvalid_o = a_rv & ~rst_i;
  assign bus.b_rvalid_o = b_rv & ~rst_i;
  assign bus.c_rvalid_o = c_rv & ~rst_i;
  assign bus.a_rdata_o = a_rd;
  assign bus.b_rdata_o = b_rd;
  assign bus.c_rdata_o = c_rd;
  // s1 tracks ops the macro sampled last edge; s2 captures macro dout one cycle later
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {s1_vld0, s1_we, s1_vld1, a_rv, b_rv, c_rv} <= '0;
      s1_id <= REQ_A;
      a_rd <= '0;
      b_rd <= '0;
      c_rd <= '0;
    end else begin
      s1_vld0 <= p0_fire;
      s1_we <= p0.we;
      s1_id <= gnt_id;
      s1_vld1 <= c_fire;
      a_rv <= rd0 & (s1_id == REQ_A);
      b_rv <= rd0 & (s1_id == REQ_B);
      c_rv <= s1_vld1;
      if (rd0 && s1_id == REQ_A) a_rd <= bus.dout0_i;
      if (rd0 && s1_id == REQ_B) b_rd <= bus.dout0_i;
      if (s1_vld1) c_rd <= bus.dout1_i;
    end
  end
endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// tb_sram_1rw1r_arbiter: directed scenarios against sram_1rw1r_arbiter with a behavioural 1RW+1R macro
module tb_sram_1rw1r_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [512];
  sram_1rw1r_arbiter_if bus ();
  sram_1rw1r_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!bus.csb0_o) begin
      if (!bus.web0_o) begin
        for (int k = 0; k < 4; k++)
          if (bus.wmask0_o[k]) mem[bus.addr0_o][8*k +: 8] = bus.din0_o[8*k +: 8];
      end else bus.dout0_i <= mem[bus.addr0_o];
    end
    if (!bus.csb1_o) bus.dout1_i <= mem[bus.addr1_o];
  end
  task step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task set_a(input logic r, input logic we, input logic [3:0] be, input logic [8:0] addr, input logic [31:0] d);
    bus.a_req_i = r; bus.a_we_i = we; bus.a_be_i = be; bus.a_addr_i = addr; bus.a_wdata_i = d;
  endtask
  task set_b(input logic r, input logic we, input logic [3:0] be, input logic [8:0] addr, input logic [31:0] d);
    bus.b_req_i = r; bus.b_we_i = we; bus.b_be_i = be; bus.b_addr_i = addr; bus.b_wdata_i = d;
  endtask
  task set_c(input logic r, input logic [8:0] addr);
    bus.c_req_i = r; bus.c_addr_i = addr;
  endtask
  task idle;
    set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0); set_c(0, 0);
  endtask
  task test_reset;
    rst = 1; set_a(1, 1, 4'hF, 9'h011, 32'h1); set_b(1, 0, 0, 9'h012, 0); set_c(1, 9'h013);
    #1;
    checks++; if (bus.a_gnt_o !== 1'b0 || bus.b_gnt_o !== 1'b0 || bus.c_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt got a%b b%b c%b exp 000", bus.a_gnt_o, bus.b_gnt_o, bus.c_gnt_o); end
    checks++; if (bus.csb0_o !== 1'b1 || bus.csb1_o !== 1'b1) begin errors++; $display("FAIL rst_csb got %b%b exp 11", bus.csb0_o, bus.csb1_o); end
    checks++; if (bus.addr0_o !== 9'h0 || bus.wmask0_o !== 4'h0 || bus.addr1_o !== 9'h0) begin errors++; $display("FAIL rst_idle_drive got addr0 %h wm %h addr1 %h exp 0", bus.addr0_o, bus.wmask0_o, bus.addr1_o); end
    step;
    checks++; if (bus.a_rvalid_o !== 1'b0 || bus.b_rvalid_o !== 1'b0 || bus.c_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b%b%b exp 000", bus.a_rvalid_o, bus.b_rvalid_o, bus.c_rvalid_o); end
    checks++; if (bus.a_rdata_o !== 32'h0 || bus.b_rdata_o !== 32'h0 || bus.c_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h %h %h exp 0", bus.a_rdata_o, bus.b_rdata_o, bus.c_rdata_o); end
    rst = 0; idle;
    step;
  endtask
  task test_write_read;
    set_a(1, 1, 4'hF, 9'h010, 32'hDEADBEEF);
    #1;
    checks++; if (bus.a_gnt_o !== 1'b1 || bus.csb0_o !== 1'b0 || bus.web0_o !== 1'b0) begin errors++; $display("FAIL wr_gnt got gnt %b csb %b web %b exp 1 0 0", bus.a_gnt_o, bus.csb0_o, bus.web0_o); end
    checks++; if (bus.wmask0_o !== 4'hF || bus.addr0_o !== 9'h010 || bus.din0_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_drive got wm %h addr %h din %h exp f 010 deadbeef", bus.wmask0_o, bus.addr0_o, bus.din0_o); end
    step;
    set_a(1, 0, 4'hF, 9'h010, 0);
    #1;
    checks++; if (bus.a_gnt_o !== 1'b1 || bus.web0_o !== 1'b1 || bus.wmask0_o !== 4'h0) begin errors++; $display("FAIL rd_gnt got gnt %b web %b wm %h exp 1 1 0", bus.a_gnt_o, bus.web0_o, bus.wmask0_o); end
    step; idle; #1;
    checks++; if (bus.a_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_early got %b exp 0", bus.a_rvalid_o); end
    step;
    checks++; if (bus.a_rvalid_o !== 1'b1 || bus.a_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_resp got v%b %h exp v1 deadbeef", bus.a_rvalid_o, bus.a_rdata_o); end
    checks++; if (bus.b_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_b_quiet got %b exp 0", bus.b_rvalid_o); end
    step;
    checks++; if (bus.a_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_one_cycle got %b exp 0", bus.a_rvalid_o); end
  endtask
  task test_rr;
    mem[9'h040] = 32'h0A0A0A0A; mem[9'h050] = 32'h0B0B0B0B;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin set_a(1, 0, 0, 9'h040, 0); set_b(1, 0, 0, 9'h050, 0); end else idle;
      #1;
      if (i < 6) begin
        checks++; if (bus.a_gnt_o !== (i % 2 == 0) || bus.b_gnt_o !== (i % 2 == 1)) begin errors++; $display("FAIL rr_gnt[%0d] got a%b b%b exp a%b", i, bus.a_gnt_o, bus.b_gnt_o, i % 2 == 0); end
      end
      if (i >= 2) begin
        checks++; if (bus.a_rvalid_o !== (i % 2 == 0) || bus.b_rvalid_o !== (i % 2 == 1)) begin errors++; $display("FAIL rr_rvalid[%0d] got a%b b%b exp a%b", i, bus.a_rvalid_o, bus.b_rvalid_o, i % 2 == 0); end
        checks++; if ((i % 2 == 0) ? bus.a_rdata_o !== 32'h0A0A0A0A : bus.b_rdata_o !== 32'h0B0B0B0B) begin errors++; $display("FAIL rr_rdata[%0d] got a %h b %h", i, bus.a_rdata_o, bus.b_rdata_o); end
      end
      step;
    end
  endtask
  task test_be;
    mem[9'h020] = 32'h11223344;
    set_a(1, 1, 4'h3, 9'h020, 32'hAABBCCDD); step;
    set_a(1, 0, 0, 9'h020, 0); step;
    set_a(1, 1, 4'h0, 9'h020, 32'hFFFFFFFF); #1;
    checks++; if (bus.csb0_o !== 1'b0 || bus.web0_o !== 1'b0 || bus.wmask0_o !== 4'h0) begin errors++; $display("FAIL be0_drive got csb %b web %b wm %h exp 0 0 0", bus.csb0_o, bus.web0_o, bus.wmask0_o); end
    step;
    set_a(1, 0, 0, 9'h020, 0); #1;
    checks++; if (bus.a_rvalid_o !== 1'b1 || bus.a_rdata_o !== 32'h1122CCDD) begin errors++; $display("FAIL be3_read got v%b %h exp v1 1122ccdd", bus.a_rvalid_o, bus.a_rdata_o); end
    step; idle; step; #1;
    checks++; if (bus.a_rvalid_o !== 1'b1 || bus.a_rdata_o !== 32'h1122CCDD) begin errors++; $display("FAIL be0_read got v%b %h exp v1 1122ccdd", bus.a_rvalid_o, bus.a_rdata_o); end
    step;
  endtask
  task test_collide;
    mem[9'h030] = 32'h0; mem[9'h031] = 32'h31313131;
    set_a(1, 1, 4'hF, 9'h030, 32'h5A5A5A5A); set_c(1, 9'h030); #1;
    checks++; if (bus.c_gnt_o !== 1'b0 || bus.csb1_o !== 1'b1 || bus.a_gnt_o !== 1'b1) begin errors++; $display("FAIL col_stall got c%b csb1 %b a%b exp 0 1 1", bus.c_gnt_o, bus.csb1_o, bus.a_gnt_o); end
    step; set_a(0, 0, 0, 0, 0); #1;
    checks++; if (bus.c_gnt_o !== 1'b1 || bus.addr1_o !== 9'h030) begin errors++; $display("FAIL col_retry got c%b addr1 %h exp 1 030", bus.c_gnt_o, bus.addr1_o); end
    step; set_c(0, 0); #1;
    checks++; if (bus.c_rvalid_o !== 1'b0) begin errors++; $display("FAIL col_early got %b exp 0", bus.c_rvalid_o); end
    step;
    checks++; if (bus.c_rvalid_o !== 1'b1 || bus.c_rdata_o !== 32'h5A5A5A5A) begin errors++; $display("FAIL col_resp got v%b %h exp v1 5a5a5a5a", bus.c_rvalid_o, bus.c_rdata_o); end
    step;
    set_a(1, 1, 4'hF, 9'h030, 32'h12345678); set_c(1, 9'h031); #1;
    checks++; if (bus.c_gnt_o !== 1'b1 || bus.c_rvalid_o !== 1'b0) begin errors++; $display("FAIL col_other_addr got gnt %b rv %b exp 1 0", bus.c_gnt_o, bus.c_rvalid_o); end
    step; set_a(1, 0, 0, 9'h030, 0); set_c(1, 9'h030); #1;
    checks++; if (bus.c_gnt_o !== 1'b1 || bus.a_gnt_o !== 1'b1) begin errors++; $display("FAIL col_read_same got c%b a%b exp 1 1", bus.c_gnt_o, bus.a_gnt_o); end
    step; idle; #1;
    checks++; if (bus.c_rvalid_o !== 1'b1 || bus.c_rdata_o !== 32'h31313131) begin errors++; $display("FAIL col_other_resp got v%b %h exp v1 31313131", bus.c_rvalid_o, bus.c_rdata_o); end
    step;
    checks++; if (bus.c_rdata_o !== 32'h12345678 || bus.a_rdata_o !== 32'h12345678 || bus.a_rvalid_o !== 1'b1) begin errors++; $display("FAIL col_same_resp got c %h a %h av %b exp 12345678 x2 v1", bus.c_rdata_o, bus.a_rdata_o, bus.a_rvalid_o); end
    step;
  endtask
  task test_reset_mid;
    set_a(1, 0, 0, 9'h040, 0); set_b(1, 0, 0, 9'h050, 0); #1;
    checks++; if (bus.a_gnt_o !== 1'b1) begin errors++; $display("FAIL mid_first got %b exp 1", bus.a_gnt_o); end
    step; rst = 1; set_c(1, 9'h001); #1;
    checks++; if (bus.a_gnt_o !== 1'b0 || bus.b_gnt_o !== 1'b0 || bus.c_gnt_o !== 1'b0 || bus.csb0_o !== 1'b1 || bus.csb1_o !== 1'b1) begin errors++; $display("FAIL mid_rst_drive got gnt %b%b%b csb %b%b exp 000 11", bus.a_gnt_o, bus.b_gnt_o, bus.c_gnt_o, bus.csb0_o, bus.csb1_o); end
    checks++; if (bus.a_rvalid_o !== 1'b0 || bus.b_rvalid_o !== 1'b0 || bus.c_rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid got %b%b%b exp 000", bus.a_rvalid_o, bus.b_rvalid_o, bus.c_rvalid_o); end
    step; rst = 0; set_c(0, 0); #1;
    checks++; if (bus.a_gnt_o !== 1'b1 || bus.b_gnt_o !== 1'b0) begin errors++; $display("FAIL mid_ptr got a%b b%b exp a1 b0", bus.a_gnt_o, bus.b_gnt_o); end
    checks++; if (bus.a_rvalid_o !== 1'b0 || bus.a_rdata_o !== 32'h0) begin errors++; $display("FAIL mid_dropped got v%b %h exp v0 0", bus.a_rvalid_o, bus.a_rdata_o); end
    step; idle; #1;
    checks++; if (bus.a_rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_quiet got %b exp 0", bus.a_rvalid_o); end
    step;
    checks++; if (bus.a_rvalid_o !== 1'b1 || bus.a_rdata_o !== 32'h0A0A0A0A) begin errors++; $display("FAIL mid_recover got v%b %h exp v1 0a0a0a0a", bus.a_rvalid_o, bus.a_rdata_o); end
    step;
  endtask
  task test_back_to_back;
    for (int i = 0; i < 8; i++) mem[i] = 32'hC0000000 + i;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin set_c(1, 9'(i)); set_a(1, 1, 4'hF, 9'h100 + 9'(i), 32'(i)); end else idle;
      #1;
      if (i < 8) begin
        checks++; if (bus.c_gnt_o !== 1'b1 || bus.a_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got c%b a%b exp 1 1", i, bus.c_gnt_o, bus.a_gnt_o); end
      end
      if (i >= 2 && i < 10) begin
        checks++; if (bus.c_rvalid_o !== 1'b1 || bus.c_rdata_o !== 32'hC0000000 + 32'(i - 2)) begin errors++; $display("FAIL b2b_resp[%0d] got v%b %h exp v1 %h", i, bus.c_rvalid_o, bus.c_rdata_o, 32'hC0000000 + 32'(i - 2)); end
      end
      if (i == 10) begin
        checks++; if (bus.c_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", bus.c_rvalid_o); end
      end
      step;
    end
    checks++; if (mem[9'h107] !== 32'h7) begin errors++; $display("FAIL b2b_writes got %h exp 7", mem[9'h107]); end
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    bus.dout0_i = '0; bus.dout1_i = '0;
    idle;
    @(negedge clk);
    test_reset;
    test_write_read;
    test_rr;
    test_be;
    test_collide;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
